alu_self_test: RTL and testbench

Hardware self-checking harness for the 10-bit two-operand ALU (`a`, `b`, `mode` → `y`, `is_zero`). On `start`, it sweeps operand pairs `a = i`, `b = 1023 − i` for i = 0…1022 across all four modes, compares the ALU response against an internal golden model, and reports pass/fail, an error count and the first failing vector. It sits beside the ALU on the lab board as its built-in self test, driving the ALU inputs and reading its outputs.

---
 rtl/alu_self_test_pkg.sv | 18 +
 rtl/alu_self_test_if.sv | 13 +
 rtl/alu_golden.sv | 26 ++
 rtl/alu_self_test.sv | 121 ++++++++++++
 tb/tb_alu_self_test.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_self_test_pkg.sv
// Shared constants and types for the ALU built-in self test.
package alu_self_test_pkg;

  localparam logic [1:0] MODE_A   = 2'd0;
  localparam logic [1:0] MODE_B   = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;
  localparam logic [1:0] MODE_SUB = 2'd3;

  localparam int ERR_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_self_test_if.sv
// Operand/result bus between the self test (master) and the ALU under test (slave).
interface alu_self_test_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [WIDTH-1:0] y;
  logic             is_zero;

  modport master (output a, b, mode, input y, is_zero);
  modport slave  (input a, b, mode, output y, is_zero);
endinterface

// File: rtl/alu_golden.sv
// Combinational reference ALU: expected result and zero flag for one vector.
module alu_golden
  import alu_self_test_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             is_zero
);

  always_comb begin
    y = '0;
    case (mode)
      MODE_A:   y = a;
      MODE_B:   y = b;
      MODE_ADD: y = a + b;
      MODE_SUB: y = a - b;
      default:  y = '0;
    endcase
    is_zero = (y == '0);
  end

endmodule

// File: rtl/alu_self_test.sv
// Sweeps a = i, b = ~i over all modes, checks the ALU against alu_golden,
// and records the error count and the first failing vector.
//
// state    | meaning
// ST_IDLE  | out of reset, waiting for start
// ST_APPLY | vector driven, settle timer counting down
// ST_CHECK | compare ALU response, advance to next vector
// ST_DONE  | sweep finished, results held until next start
module alu_self_test
  import alu_self_test_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  alu_self_test_if.master     alu,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    error_count,
  output logic [WIDTH-1:0]    fail_a,
  output logic [WIDTH-1:0]    fail_b,
  output logic [1:0]          fail_mode,
  output logic [WIDTH-1:0]    fail_y
);

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] IDX_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    idx;
  logic [1:0]          mode_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [WIDTH-1:0]    exp_y;
  logic                exp_zero;
  logic                accept, last_vec, mismatch;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_vec = (idx == IDX_LAST) && (mode_cnt == MODE_SUB);
  assign mismatch = (alu.y != exp_y) || (alu.is_zero != exp_zero);

  alu_golden #(.WIDTH(WIDTH)) u_golden (
    .a       (idx),
    .b       (~idx),
    .mode    (mode_cnt),
    .y       (exp_y),
    .is_zero (exp_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_APPLY;
      ST_APPLY: if (settle_cnt == '0) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = last_vec ? ST_DONE : ST_APPLY;
      ST_DONE:  if (accept) state_nxt = ST_APPLY;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operands are forced to 0 outside a sweep so the ALU sees a quiet bus.
  always_comb begin
    busy     = (state == ST_APPLY) || (state == ST_CHECK);
    done     = (state == ST_DONE);
    pass     = done && (error_count == '0);
    alu.a    = busy ? idx : '0;
    alu.b    = busy ? ~idx : '0;
    alu.mode = busy ? mode_cnt : MODE_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      mode_cnt    <= MODE_A;
      settle_cnt  <= '0;
      error_count <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_mode   <= MODE_A;
      fail_y      <= '0;
    end else if (accept) begin
      idx         <= '0;
      mode_cnt    <= MODE_A;
      settle_cnt  <= SETTLE_LOAD;
      error_count <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_mode   <= MODE_A;
      fail_y      <= '0;
    end else if (state == ST_APPLY) begin
      if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
    end else if (state == ST_CHECK) begin
      settle_cnt <= SETTLE_LOAD;
      if (mismatch) begin
        error_count <= error_count + ERR_W'(1);
        if (error_count == '0) begin
          fail_a    <= idx;
          fail_b    <= ~idx;
          fail_mode <= mode_cnt;
          fail_y    <= alu.y;
        end
      end
      if (last_vec) begin
        idx      <= '0;
        mode_cnt <= MODE_A;
      end else begin
        mode_cnt <= mode_cnt + 2'd1;
        if (mode_cnt == MODE_SUB) idx <= idx + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_self_test.sv
// Bench for alu_self_test: a behavioural ALU with selectable faults drives the
// bus; per-sweep expected results are queued at start and checked at done.
module tb_alu_self_test;
  import alu_self_test_pkg::*;

  localparam int WIDTH    = 10;
  localparam int SETTLE   = 2;
  localparam int NVEC     = (1 << WIDTH) - 1;
  localparam int SWEEP    = 4 * NVEC * (SETTLE + 1);
  localparam int TIMEOUT  = SWEEP + 500;

  typedef struct {
    int errors;
    int fa;
    int fb;
    int fm;
    int fy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy, done, pass;
  logic [ERR_W-1:0] error_count;
  logic [WIDTH-1:0] fail_a, fail_b, fail_y;
  logic [1:0]       fail_mode;
  int               fault_sel;
  int               n_checks = 0;
  int               n_fail = 0;
  exp_t             sb[$];

  alu_self_test_if #(.WIDTH(WIDTH)) alu_bus ();

  alu_self_test #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu         (alu_bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .error_count (error_count),
    .fail_a      (fail_a),
    .fail_b      (fail_b),
    .fail_mode   (fail_mode),
    .fail_y      (fail_y)
  );

  always #5 clk = ~clk;

  // fault 1: mode 3 computes b-a; fault 2: is_zero stuck at 0
  function automatic logic [WIDTH:0] alu_fn(input int a, input int b, input int m, input int fault);
    int r;
    logic z;
    case (m)
      0:       r = a;
      1:       r = b;
      2:       r = a + b;
      default: r = (fault == 1) ? (b - a) : (a - b);
    endcase
    r = r & ((1 << WIDTH) - 1);
    z = (r == 0) && (fault != 2);
    return {z, r[WIDTH-1:0]};
  endfunction

  always_comb begin
    logic [WIDTH:0] r;
    r = alu_fn(int'(alu_bus.a), int'(alu_bus.b), int'(alu_bus.mode), fault_sel);
    alu_bus.y       = r[WIDTH-1:0];
    alu_bus.is_zero = r[WIDTH];
  end

  function automatic exp_t model_sweep(input int fault);
    exp_t e;
    logic [WIDTH:0] ref_r, dut_r;
    e = '{default: 0};
    for (int i = 0; i < NVEC; i++) begin
      for (int m = 0; m < 4; m++) begin
        ref_r = alu_fn(i, NVEC - i, m, 0);
        dut_r = alu_fn(i, NVEC - i, m, fault);
        if (ref_r != dut_r) begin
          if (e.errors == 0) begin
            e.fa = i;
            e.fb = NVEC - i;
            e.fm = m;
            e.fy = int'(dut_r[WIDTH-1:0]);
          end
          e.errors++;
        end
      end
    end
    return e;
  endfunction

  task automatic check_value(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string where);
    check_value({where, "_busy"},  int'(busy), 0);
    check_value({where, "_done"},  int'(done), 0);
    check_value({where, "_pass"},  int'(pass), 0);
    check_value({where, "_errs"},  int'(error_count), 0);
    check_value({where, "_fa"},    int'(fail_a), 0);
    check_value({where, "_fb"},    int'(fail_b), 0);
    check_value({where, "_fm"},    int'(fail_mode), 0);
    check_value({where, "_fy"},    int'(fail_y), 0);
    check_value({where, "_a"},     int'(alu_bus.a), 0);
    check_value({where, "_b"},     int'(alu_bus.b), 0);
    check_value({where, "_mode"},  int'(alu_bus.mode), 0);
  endtask

  task automatic check_vec(input int k);
    int v;
    v = k / (SETTLE + 1);
    check_value($sformatf("vec_busy@%0d", k), int'(busy), 1);
    check_value($sformatf("vec_a@%0d", k),    int'(alu_bus.a), v / 4);
    check_value($sformatf("vec_b@%0d", k),    int'(alu_bus.b), NVEC - v / 4);
    check_value($sformatf("vec_mode@%0d", k), int'(alu_bus.mode), v % 4);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input int fault, input bit restart_mid);
    exp_t e;
    int   cyc;
    fault_sel = fault;
    sb.push_back(model_sweep(fault));
    pulse_start();
    cyc = 0;
    check_vec(0);
    check_value("start_done_clr", int'(done), 0);
    check_value("start_errs_clr", int'(error_count), 0);
    while (!done && cyc < TIMEOUT) begin
      @(posedge clk);
      cyc++;
      #1;
      if (restart_mid && cyc == 500) start = 1'b1;
      if (cyc == 501) start = 1'b0;
      if (cyc == 2 || cyc == 3 || cyc == 11 || cyc == 12 || cyc == 502 ||
          cyc == 6001 || cyc == SWEEP - 1)
        check_vec(cyc);
    end
    e = sb.pop_front();
    check_value($sformatf("latency_f%0d", fault), cyc, SWEEP);
    check_value("end_done", int'(done), 1);
    check_value("end_busy", int'(busy), 0);
    check_value($sformatf("pass_f%0d", fault), int'(pass), (e.errors == 0) ? 1 : 0);
    check_value($sformatf("errs_f%0d", fault), int'(error_count), e.errors);
    check_value($sformatf("fail_a_f%0d", fault), int'(fail_a), e.fa);
    check_value($sformatf("fail_b_f%0d", fault), int'(fail_b), e.fb);
    check_value($sformatf("fail_mode_f%0d", fault), int'(fail_mode), e.fm);
    check_value($sformatf("fail_y_f%0d", fault), int'(fail_y), e.fy);
    check_value("end_a", int'(alu_bus.a), 0);
    check_value("end_b", int'(alu_bus.b), 0);
    check_value("end_mode", int'(alu_bus.mode), 0);
    repeat (3) @(posedge clk);
    #1;
    check_value("hold_done", int'(done), 1);
    check_value("hold_errs", int'(error_count), e.errors);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    fault_sel = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(0, 1'b1);

    // reset in the middle of a faulty sweep
    fault_sel = 1;
    pulse_start();
    repeat (600) @(posedge clk);
    #1;
    check_value("mid_errs", int'(error_count), 50);
    check_value("mid_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
